// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - Avalon-MM multiplexed seven-segment scan controller
module hex_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] dig_n,
    output logic                  frame_tick
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] LAST_PRESC = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]    ND4        = 4'(NUM_DIGITS);

    typedef enum logic [1:0] {S_OFF, S_GAP, S_SHOW} state_t;

    logic [31:0]   data;
    logic          enable;
    logic [7:0]    blank_mask;
    logic [7:0]    blink_mask;
    state_t        state;
    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic [15:0]   frame_cnt;
    logic          wr;

    assign wr = chipselect & ~write_n;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;  default: decode = 7'h0E;
        endcase
    endfunction

    // A blanked or blink-dark digit keeps every strobe high for its slot.
    function automatic logic [NUM_DIGITS-1:0] strobe(input logic [2:0] i, input logic dark);
        logic [NUM_DIGITS-1:0] s;
        for (int k = 0; k < NUM_DIGITS; k++)
            s[k] = dark || (3'(k) != i);
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data       <= '0;
            enable     <= 1'b0;
            blank_mask <= '0;
            blink_mask <= '0;
        end else if (wr) begin
            case (address)
                2'd0: data <= writedata;
                2'd1: begin
                    enable     <= writedata[0];
                    blank_mask <= writedata[15:8];
                    blink_mask <= writedata[23:16];
                end
                2'd3: if ({1'b0, writedata[6:4]} < ND4)
                    data[{writedata[6:4], 2'b00} +: 4] <= writedata[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_OFF;
            presc      <= '0;
            idx        <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            frame_cnt  <= '0;
            seg_n      <= 7'h7F;
            dig_n      <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (!enable) begin
                state     <= S_OFF;
                presc     <= '0;
                idx       <= '0;
                blink_cnt <= '0;
                phase     <= 1'b0;
                seg_n     <= 7'h7F;
                dig_n     <= '1;
            end else begin
                case (state)
                    S_OFF: begin
                        state <= S_GAP;
                        seg_n <= 7'h7F;
                        dig_n <= '1;
                    end
                    S_GAP: begin
                        state <= S_SHOW;
                        presc <= '0;
                        seg_n <= decode(data[{idx, 2'b00} +: 4]);
                        dig_n <= strobe(idx, blank_mask[idx] | (blink_mask[idx] & phase));
                    end
                    S_SHOW: begin
                        if (presc == LAST_PRESC) begin
                            state <= S_GAP;
                            presc <= '0;
                            seg_n <= 7'h7F;
                            dig_n <= '1;
                            if (idx == LAST_IDX) begin
                                idx        <= '0;
                                frame_tick <= 1'b1;
                                frame_cnt  <= frame_cnt + 16'd1;
                                if (blink_cnt == LAST_BLINK) begin
                                    blink_cnt <= '0;
                                    phase     <= ~phase;
                                end else begin
                                    blink_cnt <= blink_cnt + BW'(1);
                                end
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                            seg_n <= decode(data[{idx, 2'b00} +: 4]);
                            dig_n <= strobe(idx, blank_mask[idx] | (blink_mask[idx] & phase));
                        end
                    end
                    default: state <= S_OFF;
                endcase
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata = data;
            2'd1: readdata = {8'h00, blink_mask, blank_mask, 7'h00, enable};
            2'd2: readdata = {frame_cnt, 11'h000, enable, phase, idx};
            default: readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - randomized self-checking bench for hex_scan_ctrl
module tb_hex_scan_ctrl;
    localparam int ND = 8;
    localparam int SD = 4;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = 2'd2;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [6:0]    seg_n;
    logic [ND-1:0] dig_n;
    logic          frame_tick;

    hex_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .seg_n(seg_n), .dig_n(dig_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_vec = 0;
    int n_err = 0;

    // Reference state: registers as software sees them, plus time since enable
    logic [31:0] m_data = '0;
    logic        m_en = 1'b0;
    logic [7:0]  m_blank = '0;
    logic [7:0]  m_blink = '0;
    logic [15:0] m_frames = '0;
    int          t = 0;
    int          run_frames = 0;
    logic [2:0]  e_idx = '0;
    logic        e_phase = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [1:0] a);
        case (a)
            2'd0: return m_data;
            2'd1: return {8'h00, m_blink, m_blank, 7'h00, m_en};
            2'd2: return {m_frames, 11'h000, m_en, e_phase, e_idx};
            default: return 32'h0;
        endcase
    endfunction

    task automatic cycle();
        logic [6:0]    exp_seg;
        logic [ND-1:0] exp_dig;
        logic          exp_tick;
        @(posedge clk);
        #1;
        if (m_en) t++; else t = 0;
        exp_seg = 7'h7F;
        exp_dig = '1;
        exp_tick = 1'b0;
        e_idx = '0;
        if (t >= 2) begin
            int pos, slot, r, d;
            pos  = t - 2;
            slot = pos / (SD + 1);
            r    = pos % (SD + 1);
            d    = slot % ND;
            if (r < SD) begin
                e_idx = 3'(d);
                exp_seg = seg_tab[m_data[d*4 +: 4]];
                if (!(m_blank[d] || (m_blink[d] && ((run_frames / BF) % 2 == 1))))
                    exp_dig = ~(8'h01 << d);
            end else begin
                e_idx = 3'((d + 1) % ND);
                if (d == ND - 1) begin
                    exp_tick = 1'b1;
                    run_frames++;
                    m_frames++;
                end
            end
        end
        if (t == 0) run_frames = 0;
        e_phase = ((run_frames / BF) % 2) == 1;
        check("seg_n", 32'(seg_n), 32'(exp_seg));
        check("dig_n", 32'(dig_n), 32'(exp_dig));
        check("frame_tick", 32'(frame_tick), 32'(exp_tick));
        if (chipselect && !write_n) begin
            case (address)
                2'd0: m_data = writedata;
                2'd1: begin
                    m_en = writedata[0];
                    m_blank = writedata[15:8];
                    m_blink = writedata[23:16];
                end
                2'd3: if (int'(writedata[6:4]) < ND) m_data[int'(writedata[6:4])*4 +: 4] = writedata[3:0];
                default: ;
            endcase
        end
        check("readdata", readdata, mread(address));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        cycle();
        chipselect = 1'b0;
        write_n = 1'b1;
        address = 2'd2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #2;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            check("reset_read", readdata, 32'h0);
        end
        check("reset_seg", 32'(seg_n), 32'h7F);
        check("reset_dig", 32'(dig_n), 32'hFF);
        check("reset_tick", 32'(frame_tick), 32'h0);
        address = 2'd2;
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        for (int run = 0; run < 8; run++) begin
            logic [31:0] d, c;
            int ncyc;
            wr(2'd1, 32'h0);
            idle(3);
            d = (run == 0) ? 32'h76543210 : $urandom;
            if (run == 0)      c = 32'h000001;
            else if (run == 1) c = 32'h000401;
            else if (run == 2) c = 32'h010001;
            else begin
                c = 32'h1;
                if ($urandom_range(0, 1) == 1) c[15:8] = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) c[23:16] = 8'($urandom_range(0, 255));
            end
            wr(2'd0, d);
            wr(2'd1, c);
            ncyc = (run < 3) ? 260 : $urandom_range(50, 250);
            for (int i = 0; i < ncyc; i++) begin
                if (run == 0 && i == 70)
                    wr(2'd3, 32'h3F);
                else if (run > 0 && $urandom_range(0, 24) == 0)
                    wr(2'd3, 32'($urandom_range(0, 127)));
                else begin
                    address = 2'($urandom_range(0, 3));
                    cycle();
                end
            end
            address = 2'd2;
        end

        wr(2'd1, 32'h1);
        idle(17);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_seg", 32'(seg_n), 32'h7F);
        check("async_dig", 32'(dig_n), 32'hFF);
        check("async_tick", 32'(frame_tick), 32'h0);
        m_data = '0; m_en = 1'b0; m_blank = '0; m_blink = '0;
        m_frames = '0; t = 0; run_frames = 0;
        #3;
        reset_n = 1'b1;
        address = 2'd0;
        cycle();
        address = 2'd1;
        cycle();
        address = 2'd2;
        wr(2'd0, 32'hFEDCBA98);
        wr(2'd1, 32'h1);
        idle(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Avalon-MM slave that owns a bank of multiplexed seven-segment digits and sequences them. Software writes hex nibble values and display control. The block runs a prescaled scan state machine, decodes the current nibble to active-low segments, and applies per-digit blanking and blinking. It sits on the Nios II data bus beside the plain PIO peripherals and replaces per-digit 7-bit output ports with one shared segment bus plus digit strobes.

## Interface
- NUM_DIGITS, 8 — number of scanned digits, 1..8.
- SCAN_DIV, 50000 — clk cycles each digit is lit (SHOW length), ≥2.
- BLINK_FRAMES, 64 — full scan frames per blink half-period, ≥1.

- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero wait states.
- seg_n  out  7  segments g..a (bit0 = a), active-low, registered.
- dig_n  out  NUM_DIGITS  one-hot-low digit strobe, registered.
- frame_tick  out  1  one-cycle pulse at end of each full frame.

## Operation
- Registers. A write occurs when chipselect=1 and write_n=0.
  - 0 DATA (rw): digit i = bits [4i+3:4i].
  - 1 CTRL (rw): [0] enable, [15:8] blank mask, [23:16] blink mask. Other bits read 0.
  - 2 STATUS (ro): [2:0] current digit index, [3] blink phase, [4] enable, [31:16] frame counter (wraps at 0xFFFF).
  - 3 POKE (wo, reads 0): writes nibble writedata[3:0] into DATA digit writedata[6:4]. Other DATA bits are unchanged. Index ≥ NUM_DIGITS is ignored.
- Mask bits at or above NUM_DIGITS are stored but have no effect.
- State machine:
  - OFF: dig_n all 1, seg_n all 1, prescaler=0, index=0. Leaves to GAP when enable=1.
  - GAP: lasts 1 cycle, dig_n all 1 (anti-ghosting). Goes to SHOW.
  - SHOW: lasts SCAN_DIV cycles. Lights digit `index`. At the last cycle, goes to GAP and index advances.
  - Index wraps from NUM_DIGITS-1 to 0. On the wrap, frame_tick pulses, the frame counter increments, and a blink counter increments. When the blink counter reaches BLINK_FRAMES, it clears and blink phase toggles.
- Any state with enable=0 goes to OFF next cycle. This clears index, prescaler, blink counter and blink phase. The frame counter is kept.
- Digit display in SHOW: dig_n[index]=0 unless blank[index]=1 or (blink[index]=1 and phase=1). In those cases dig_n stays all 1.
- Decode (seg_n hex, digit 0..F): 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
- DATA and CTRL writes take effect the next cycle; lit outputs reflect them one cycle later (registered outputs).

## Timing
- Reset values: DATA=0, CTRL=0, state OFF, seg_n=7'h7F, dig_n all 1, frame_tick=0, frame counter 0, phase 0.
- Outputs are registered from the state and index of the previous cycle.
  - First lit digit: dig_n[0]=0 exactly 3 cycles after the enable write cycle (write→OFF→GAP→SHOW registered).
- Per-digit period is SCAN_DIV+1 cycles; frame period is NUM_DIGITS·(SCAN_DIV+1) cycles.
- frame_tick is high in the cycle after the SHOW of the last digit ends, coincident with the GAP output.
- Reset asserted mid-scan forces all outputs to their reset values asynchronously. The next enable starts at digit 0.
- Clearing enable mid-SHOW blanks the outputs 2 cycles after the write cycle; no partial digit resumes.

## Test plan
- Reset, then read all regs → readdata 0; seg_n=7F, dig_n=FF, frame_tick=0.
- SCAN_DIV=4, NUM_DIGITS=8. Write DATA=0x76543210, CTRL=1 → digits 0..7 lit in order, each 4 cycles with a 1-cycle all-off gap; seg_n 40,79,24,30,19,12,02,78. frame_tick every 40 cycles; STATUS[31:16]=2 after 2 frames.
- POKE 0x3F (digit 3 ← F) while scanning → DATA reads 0x7654F210; digit 3 shows 0E on its next slot.
- CTRL=0x00_04_01 (blank digit 2) → dig_n[2] never low, other timing unchanged. CTRL=0x01_00_01 with BLINK_FRAMES=2 → digit 0 lit frames 0–1, dark frames 2–3, lit 4–5.
- Clear enable while digit 5 is lit → outputs blank 2 cycles later, STATUS[2:0]=0. Re-enable → digit 0 first.
- Assert reset_n low mid-SHOW → seg_n=7F, dig_n=FF immediately; DATA and CTRL read 0 after release.
